// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Address and control sequencer for an in-place radix-2 DIT FFT built from
//   two ping-pong complex RAM banks, one butterfly unit and a twiddle ROM.
//   A start request walks all LOG2_N stages, issuing one butterfly per cycle.
//   Each stage is followed by a drain gap of BFU_LATENCY cycles, so the next
//   stage never reads a location that is still in flight.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active high
//   start_i        start request, sampled only in IDLE
//   busy_o         high from the cycle after start is accepted through DONE
//   done_o         one-cycle pulse after the final write-back
//   rd_addr_a_o    butterfly upper-leg read address
//   rd_addr_b_o    butterfly lower-leg read address
//   rd_valid_o     read addresses valid this cycle
//   twiddle_idx_o  twiddle ROM index, aligned with the read addresses
//   wr_addr_a_o    write-back address, leg A
//   wr_addr_b_o    write-back address, leg B
//   wr_en_o        write strobe for the destination bank
//   memsel_o       0: read bank0 / write bank1, 1: read bank1 / write bank0
//   stage_o        current stage index
//   result_bank_o  bank holding the final result
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i
// RUN   | issuing butterflies k = 0 .. N/2-1 of the current stage
// DRAIN | BFU_LATENCY cycles with no reads; pending writes land here
// DONE  | one-cycle completion pulse, then back to IDLE

module fft_stage_sequencer #(
    parameter int LOG2_N      = 10,
    parameter int BFU_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [LOG2_N-1:0]          rd_addr_a_o,
    output logic [LOG2_N-1:0]          rd_addr_b_o,
    output logic                       rd_valid_o,
    output logic [LOG2_N-2:0]          twiddle_idx_o,
    output logic [LOG2_N-1:0]          wr_addr_a_o,
    output logic [LOG2_N-1:0]          wr_addr_b_o,
    output logic                       wr_en_o,
    output logic                       memsel_o,
    output logic [$clog2(LOG2_N)-1:0]  stage_o,
    output logic                       result_bank_o
);

    localparam int KW = LOG2_N - 1;
    localparam int SW = $clog2(LOG2_N);
    localparam int DW = (BFU_LATENCY < 2) ? 1 : $clog2(BFU_LATENCY);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [LOG2_N-1:0] ONE_N     = LOG2_N'(1);
    localparam logic [KW-1:0]     ONE_K     = KW'(1);
    localparam logic [SW-1:0]     ONE_S     = SW'(1);
    localparam logic [DW-1:0]     ONE_D     = DW'(1);
    localparam logic [SW-1:0]     LAST_STG  = SW'(LOG2_N - 1);
    localparam logic [DW-1:0]     DRAIN_TOP = DW'(BFU_LATENCY - 1);

    logic [1:0]     state;
    logic [KW-1:0]  k;
    logic [SW-1:0]  stage;
    logic           memsel;
    logic [DW-1:0]  drain_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            stage     <= '0;
            memsel    <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state  <= ST_RUN;
                        k      <= '0;
                        stage  <= '0;
                        memsel <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // k is all ones on the last butterfly of the stage
                    if (&k) begin
                        k         <= '0;
                        drain_cnt <= DRAIN_TOP;
                        state     <= ST_DRAIN;
                    end else begin
                        k <= k + ONE_K;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        if (stage == LAST_STG) begin
                            state <= ST_DONE;
                        end else begin
                            stage  <= stage + ONE_S;
                            memsel <= ~memsel;
                            state  <= ST_RUN;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - ONE_D;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic              running;
    logic [LOG2_N-1:0] k_ext;
    logic [LOG2_N-1:0] half;
    logic [LOG2_N-1:0] low_bits;
    logic [LOG2_N-1:0] addr_a;
    logic [LOG2_N-1:0] addr_b;
    logic [KW-1:0]     twiddle;

    // Insert a zero at bit position 'stage' of k to get the upper leg;
    // the lower leg is the same index with that bit set.
    always_comb begin
        running  = (state == ST_RUN);
        k_ext    = {1'b0, k};
        half     = ONE_N << stage;
        low_bits = k_ext & (half - ONE_N);
        addr_a   = (((k_ext >> stage) << 1) << stage) | low_bits;
        addr_b   = addr_a | half;
        // low_bits < 2^stage <= N/2, so its top bit is always zero
        twiddle  = low_bits[KW-1:0] << (KW - stage);
    end

    assign rd_valid_o    = running;
    assign rd_addr_a_o   = running ? addr_a : '0;
    assign rd_addr_b_o   = running ? addr_b : '0;
    assign twiddle_idx_o = running ? twiddle : '0;

    // Write-back shift line: read strobe and addresses delayed BFU_LATENCY cycles
    logic [BFU_LATENCY-1:0] vld_sr;
    logic [LOG2_N-1:0]      a_sr [BFU_LATENCY];
    logic [LOG2_N-1:0]      b_sr [BFU_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < BFU_LATENCY; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= rd_valid_o;
            a_sr[0]   <= rd_addr_a_o;
            b_sr[0]   <= rd_addr_b_o;
            for (int i = 1; i < BFU_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                a_sr[i]   <= a_sr[i-1];
                b_sr[i]   <= b_sr[i-1];
            end
        end
    end

    assign wr_en_o     = vld_sr[BFU_LATENCY-1];
    assign wr_addr_a_o = a_sr[BFU_LATENCY-1];
    assign wr_addr_b_o = b_sr[BFU_LATENCY-1];

    assign busy_o        = (state != ST_IDLE);
    assign done_o        = (state == ST_DONE);
    assign memsel_o      = memsel;
    assign stage_o       = stage;
    // Each stage flips the bank, so an odd stage count ends in bank 1
    assign result_bank_o = ((LOG2_N % 2) == 1);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
module tb_fft_stage_sequencer;

    localparam int LAT = 2;
    localparam int L_S = 3;
    localparam int N_S = 8;
    localparam int P_S = N_S / 2 + LAT;
    localparam int T_S = L_S * P_S + 1;
    localparam int L_B = 10;
    localparam int N_B = 1024;
    localparam int P_B = N_B / 2 + LAT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small instance, LOG2_N = 3
    logic       rst_s, start_s, busy_s, done_s, rv_s, we_s, ms_s, rb_s;
    logic [2:0] ra_s, rbb_s, wa_s, wb_s;
    logic [1:0] tw_s, stg_s;

    // large instance, LOG2_N = 10
    logic       rst_b, start_b, busy_b, done_b, rv_b, we_b, ms_b, rb_b;
    logic [9:0] ra_b, rbb_b, wa_b, wb_b;
    logic [8:0] tw_b;
    logic [3:0] stg_b;

    fft_stage_sequencer #(.LOG2_N(L_S), .BFU_LATENCY(LAT)) dut_s (
        .clk(clk), .rst(rst_s), .start_i(start_s), .busy_o(busy_s), .done_o(done_s),
        .rd_addr_a_o(ra_s), .rd_addr_b_o(rbb_s), .rd_valid_o(rv_s), .twiddle_idx_o(tw_s),
        .wr_addr_a_o(wa_s), .wr_addr_b_o(wb_s), .wr_en_o(we_s), .memsel_o(ms_s),
        .stage_o(stg_s), .result_bank_o(rb_s)
    );

    fft_stage_sequencer #(.LOG2_N(L_B), .BFU_LATENCY(LAT)) dut_b (
        .clk(clk), .rst(rst_b), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .rd_addr_a_o(ra_b), .rd_addr_b_o(rbb_b), .rd_valid_o(rv_b), .twiddle_idx_o(tw_b),
        .wr_addr_a_o(wa_b), .wr_addr_b_o(wb_b), .wr_en_o(we_b), .memsel_o(ms_b),
        .stage_o(stg_b), .result_bank_o(rb_b)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // k-th index (ascending) whose bit s is clear: the upper leg of butterfly k
    function automatic int pair_a(input int s, input int k, input int n);
        int h;
        int cnt;
        h = 1 << s;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if ((i / h) % 2 == 0) begin
                if (cnt == k) return i;
                cnt++;
            end
        end
        return -1;
    endfunction

    // Cycle c (1-based after the start edge) of a small run reads a butterfly?
    function automatic bit rd_at(input int c);
        return (c >= 1) && (c <= L_S * P_S) && (((c - 1) % P_S) < N_S / 2);
    endfunction

    function automatic int stage_at(input int c);
        int s;
        s = (c - 1) / P_S;
        return (s > L_S - 1) ? L_S - 1 : s;
    endfunction

    task automatic check_small_zero(input string tag);
        check({tag, " busy"}, busy_s, 0);
        check({tag, " done"}, done_s, 0);
        check({tag, " rd_valid"}, rv_s, 0);
        check({tag, " rd_a"}, ra_s, 0);
        check({tag, " rd_b"}, rbb_s, 0);
        check({tag, " twiddle"}, tw_s, 0);
        check({tag, " wr_en"}, we_s, 0);
        check({tag, " wr_a"}, wa_s, 0);
        check({tag, " wr_b"}, wb_s, 0);
        check({tag, " memsel"}, ms_s, 0);
        check({tag, " stage"}, stg_s, 0);
    endtask

    task automatic idle_small(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle busy", busy_s, 0);
            check("idle wr_en", we_s, 0);
            check("idle rd_valid", rv_s, 0);
        end
    endtask

    // mode 0: start pulse, 1: start held through the run, 2: random start noise
    // abort_c != 0: assert reset after checking cycle abort_c
    task automatic run_small(input int mode, input int abort_c);
        int s, k, a, h, wc;
        start_s = 1'b1;
        for (int c = 1; c <= T_S; c++) begin
            @(negedge clk);
            if (mode == 0) start_s = 1'b0;
            else if (mode == 2) start_s = 1'($urandom_range(0, 1));
            check($sformatf("busy c=%0d", c), busy_s, 1);
            check($sformatf("done c=%0d", c), done_s, (c == T_S) ? 1 : 0);
            s = stage_at(c);
            check($sformatf("stage c=%0d", c), stg_s, s);
            check($sformatf("memsel c=%0d", c), ms_s, s % 2);
            check($sformatf("rd_valid c=%0d", c), rv_s, rd_at(c));
            if (rd_at(c)) begin
                k = (c - 1) % P_S;
                h = 1 << s;
                a = pair_a(s, k, N_S);
                check($sformatf("rd_a c=%0d", c), ra_s, a);
                check($sformatf("rd_b c=%0d", c), rbb_s, a + h);
                check($sformatf("twiddle c=%0d", c), tw_s, (a % h) * (N_S / (2 * h)));
            end
            wc = c - LAT;
            check($sformatf("wr_en c=%0d", c), we_s, rd_at(wc));
            if (rd_at(wc)) begin
                s = stage_at(wc);
                a = pair_a(s, (wc - 1) % P_S, N_S);
                check($sformatf("wr_a c=%0d", c), wa_s, a);
                check($sformatf("wr_b c=%0d", c), wb_s, a + (1 << s));
            end
            if (c == abort_c) begin
                rst_s = 1'b1;
                start_s = 1'b0;
                @(negedge clk);
                rst_s = 1'b0;
                check_small_zero($sformatf("after reset c=%0d", c));
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("post-reset wr_en", we_s, 0);
                    check("post-reset busy", busy_s, 0);
                end
                return;
            end
        end
        @(negedge clk);
        check("end busy", busy_s, 0);
        check("end done", done_s, 0);
        check("end rd_valid", rv_s, 0);
        check("end wr_en", we_s, 0);
        if (mode != 1) start_s = 1'b0;
    endtask

    int seen [L_B][N_B];
    int wr_cnt, busy_cnt, done_cyc, bad, ws, h, dups;
    bit finished;

    initial begin
        rst_s = 1'b1; start_s = 1'b0;
        rst_b = 1'b1; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_small_zero("reset");
        check("reset big busy", busy_b, 0);
        check("reset big wr_en", we_b, 0);
        rst_s = 1'b0;
        rst_b = 1'b0;
        check("result_bank small", rb_s, 1);
        check("result_bank big", rb_b, 0);

        idle_small(2);
        run_small(0, 0);
        idle_small($urandom_range(0, 3));
        run_small(1, 0);
        run_small(0, 0);
        idle_small(2);
        run_small(0, P_S + 3);
        run_small(0, 0);
        for (int r = 0; r < 6; r++) begin
            idle_small($urandom_range(0, 4));
            run_small(($urandom_range(0, 1) == 1) ? 2 : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, T_S)) : 0);
        end

        // Large instance: scoreboard of write-back coverage per stage
        foreach (seen[i, j]) seen[i][j] = 0;
        wr_cnt = 0; busy_cnt = 0; done_cyc = -1; bad = 0; finished = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start_b = 1'b1;
        for (int c = 1; c <= 6000 && !finished; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (busy_b) busy_cnt++;
            if (done_b) done_cyc = c;
            if (done_cyc >= 0 && c > done_cyc) finished = 1'b1;
            if (we_b) begin
                wr_cnt++;
                ws = (c - 1 - LAT) / P_B;
                if (ws < 0 || ws >= L_B) begin
                    bad++;
                end else begin
                    h = 1 << ws;
                    if ((int'(wa_b) & h) != 0 || int'(wb_b) != int'(wa_b) + h) bad++;
                    seen[ws][wa_b]++;
                    seen[ws][wb_b]++;
                end
            end
        end
        dups = 0;
        foreach (seen[i, j]) if (seen[i][j] != 1) dups++;
        check("big wr_en count", wr_cnt, L_B * N_B / 2);
        check("big done cycle", done_cyc, L_B * P_B + 1);
        check("big busy cycles", busy_cnt, L_B * P_B + 1);
        check("big write pairing errors", bad, 0);
        check("big coverage errors", dups, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
